// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute stage with a valid/ready slot. It decodes the ALU operation from
//   opcode/funct3/funct7 and registers the result. Base integer ops finish on
//   the accept edge. M-extension multiply/divide run an XLEN-step iterative
//   datapath, which stalls the input side while it works.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   in_valid    operation offered
//   in_ready    unit accepts the operation this cycle
//   opcode      instruction opcode [6:0]
//   alu_ctrl    2'b00 forces ADD, other values decode from opcode/funct
//   funct3      instruction funct3
//   funct7      instruction funct7
//   op_a, op_b  operands [XLEN-1:0]
//   out_valid   result register holds a valid result
//   out_ready   consumer takes the result this cycle
//   out_result  registered result
//   out_zero    registered (out_result == 0)
//   busy        iterative MUL/DIV in progress
module alu_exec_unit #(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [1:0]      alu_ctrl,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  // State
  state_e            r_state;
  logic [SHW-1:0]    r_cnt;
  logic [2*XLEN-1:0] r_acc;     // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic              r_neg_q;   // negate product / quotient
  logic              r_neg_r;   // negate remainder
  logic              r_sel_hi;  // upper half (MULH*) or remainder (REM*)
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;

  // Combinational
  op_e               w_op;
  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base_res;
  logic              w_is_mul, w_is_div;
  logic              w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf, w_iter;
  logic [XLEN-1:0]   w_single_res;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*XLEN-1:0] w_step, w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;
  logic [XLEN-1:0]   w_fsm_res;
  logic              w_accept, w_fsm_done, w_write;
  logic [XLEN-1:0]   w_wr_data;

  assign busy       = (r_state != S_IDLE);
  assign in_ready   = !busy && (!r_out_valid || out_ready);
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_zero   = r_zero;
  assign w_accept   = in_valid && in_ready;

  // Operation decode; every path resolves to a defined op.
  always_comb begin
    w_op = OP_ADD;
    if (alu_ctrl != 2'b00) begin
      case (opcode)
        OPC_R, OPC_I: begin
          if (opcode == OPC_R && M_EXT && funct7 == 7'b0000001) begin
            case (funct3)
              3'b000:  w_op = OP_MUL;
              3'b001:  w_op = OP_MULH;
              3'b010:  w_op = OP_MULHSU;
              3'b011:  w_op = OP_MULHU;
              3'b100:  w_op = OP_DIV;
              3'b101:  w_op = OP_DIVU;
              3'b110:  w_op = OP_REM;
              default: w_op = OP_REMU;
            endcase
          end else begin
            case (funct3)
              3'b000: begin
                // Immediate form has no SUB.
                if (opcode == OPC_R && funct7[5]) w_op = OP_SUB;
                else                              w_op = OP_ADD;
              end
              3'b001: w_op = OP_SLL;
              3'b010: w_op = OP_SLT;
              3'b011: w_op = OP_SLTU;
              3'b100: w_op = OP_XOR;
              3'b101: begin
                if (funct7[5]) w_op = OP_SRA;
                else           w_op = OP_SRL;
              end
              3'b110:  w_op = OP_OR;
              default: w_op = OP_AND;
            endcase
          end
        end
        OPC_B: begin
          case (funct3)
            3'b000, 3'b001: w_op = OP_SUB;
            3'b100, 3'b101: w_op = OP_SLT;
            3'b110, 3'b111: w_op = OP_SLTU;
            default:        w_op = OP_ADD;
          endcase
        end
        default: w_op = OP_ADD;
      endcase
    end
  end

  // Single-cycle base ALU
  assign w_shamt = op_b[SHW-1:0];

  always_comb begin
    w_base_res = op_a + op_b;
    case (w_op)
      OP_SUB:  w_base_res = op_a - op_b;
      OP_SLL:  w_base_res = op_a << w_shamt;
      OP_SLT:  w_base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: w_base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_XOR:  w_base_res = op_a ^ op_b;
      OP_SRL:  w_base_res = op_a >> w_shamt;
      OP_SRA:  w_base_res = $unsigned($signed(op_a) >>> w_shamt);
      OP_OR:   w_base_res = op_a | op_b;
      OP_AND:  w_base_res = op_a & op_b;
      default: ;
    endcase
  end

  // M-extension operand preparation: signedness per variant, then magnitudes.
  assign w_is_mul = (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU});
  assign w_is_div = (w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  assign w_a_neg  = op_a[XLEN-1] && (w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign w_b_neg  = op_b[XLEN-1] && (w_op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign w_a_mag  = w_a_neg ? -op_a : op_a;
  assign w_b_mag  = w_b_neg ? -op_b : op_b;

  // Divide-by-zero and signed overflow finish immediately without iterating.
  assign w_div_zero = (op_b == '0);
  assign w_div_ovf  = (w_op inside {OP_DIV, OP_REM}) && (op_a == MIN_NEG) && (op_b == '1);
  assign w_iter     = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);

  always_comb begin
    w_single_res = w_base_res;
    if (w_is_div) begin
      if (w_div_zero) begin
        if (w_op inside {OP_DIV, OP_DIVU}) w_single_res = '1;
        else                               w_single_res = op_a;
      end else begin
        // Overflow case: quotient is op_a, remainder is zero.
        if (w_op == OP_DIV) w_single_res = op_a;
        else                w_single_res = '0;
      end
    end
  end

  // One iteration step of the shared accumulator.
  // MUL: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  // DIV: shift the next dividend bit into the remainder, subtract if it fits (restoring).
  assign w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

  always_comb begin
    if (r_state == S_DIV) begin
      if (w_div_diff[XLEN]) w_step = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      else                  w_step = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_step = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  // Sign fix-up on the final step's value.
  assign w_prod = r_neg_q ? -w_step : w_step;
  assign w_quo  = w_step[XLEN-1:0];
  assign w_rem  = w_step[2*XLEN-1:XLEN];

  always_comb begin
    if (r_state == S_DIV) begin
      if (r_sel_hi) w_fsm_res = r_neg_r ? -w_rem : w_rem;
      else          w_fsm_res = r_neg_q ? -w_quo : w_quo;
    end else begin
      if (r_sel_hi) w_fsm_res = w_prod[2*XLEN-1:XLEN];
      else          w_fsm_res = w_prod[XLEN-1:0];
    end
  end

  assign w_fsm_done = (r_state != S_IDLE) && (r_cnt == '0);
  assign w_write    = (w_accept && !w_iter) || w_fsm_done;
  assign w_wr_data  = w_fsm_done ? w_fsm_res : w_single_res;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_sel_hi    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_iter) begin
            r_cnt    <= SHW'(XLEN - 1);
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_sel_hi <= (w_op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU});
            if (w_is_mul) begin
              r_state <= S_MUL;
              r_acc   <= {{XLEN{1'b0}}, w_b_mag};
              r_opnd  <= w_a_mag;
            end else begin
              r_state <= S_DIV;
              r_acc   <= {{XLEN{1'b0}}, w_a_mag};
              r_opnd  <= w_b_mag;
            end
          end
        end
        default: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - SHW'(1);
          if (r_cnt == '0) r_state <= S_IDLE;
        end
      endcase

      if (w_write) begin
        r_out_valid <= 1'b1;
        r_result    <= w_wr_data;
        r_zero      <= (w_wr_data == '0);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Directed bench for alu_exec_unit (XLEN=32). A second instance with
//   M_EXT=0 checks that M-extension encodings fall back to base decode.
module tb_alu_exec_unit;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;
  localparam logic [6:0] F7_M  = 7'b0000001;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero, busy;
  logic [6:0]  opcode, funct7;
  logic [1:0]  alu_ctrl;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, out_result;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_zero_b, busy_b;
  logic [31:0] out_result_b;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .M_EXT(1'b1)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_ctrl(alu_ctrl), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .busy(busy)
  );

  alu_exec_unit #(.XLEN(32), .M_EXT(1'b0)) u_dut_base (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .opcode(opcode), .alu_ctrl(alu_ctrl), .funct3(funct3), .funct7(funct7),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_result(out_result_b), .out_zero(out_zero_b), .busy(busy_b)
  );

  // Offer one op at the current negedge, wait for its result (bounded).
  // Returns at the negedge where out_valid is seen high.
  task automatic run_op(input logic [1:0] ctrl, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat);
    alu_ctrl = ctrl; opcode = opc; funct3 = f3; funct7 = f7; op_a = a; op_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
    z   = out_zero;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    alu_ctrl = 2'b00; opcode = '0; funct3 = '0; funct7 = '0; op_a = '0; op_b = '0;
    #12;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_result !== 32'h0) $display("FAIL reset_out_result: got %h want 00000000", out_result); else n_pass++;
    n_total++; if (out_zero !== 1'b1) $display("FAIL reset_out_zero: got %b want 1", out_zero); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_add();
    logic [31:0] res; logic z; int lat;
    run_op(2'b00, OPC_R, 3'b000, F7_M, 32'd5, 32'd7, res, z, lat);
    $display("add 5+7 -> %h zero=%b lat=%0d", res, z, lat);
    n_total++; if (lat != 1) $display("FAIL add_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (res !== 32'd12) $display("FAIL add_result: got %h want 0000000c", res); else n_pass++;
    n_total++; if (z !== 1'b0) $display("FAIL add_zero: got %b want 0", z); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    alu_ctrl = 2'b00; opcode = OPC_R; funct3 = 3'b000; funct7 = 7'b0;
    op_a = 32'd1; op_b = 32'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 3 + 1); b = 32'(i * 100);
      @(posedge clk);
      @(negedge clk);
      $display("b2b[%0d] %0d+%0d -> %h valid=%b", i, a, b, out_result, out_valid);
      n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_total++; if (out_result !== a + b) $display("FAIL b2b_result[%0d]: got %h want %h", i, out_result, a + b); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
      if (i < 3) begin
        op_a = 32'((i + 1) * 3 + 1); op_b = 32'((i + 1) * 100);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_rtype();
    logic [31:0] res; logic z; int lat;
    run_op(2'b10, OPC_R, 3'b000, F7_ALT, 32'h10, 32'h10, res, z, lat);
    $display("sub 0x10-0x10 -> %h zero=%b", res, z);
    n_total++; if (res !== 32'h0) $display("FAIL sub_result: got %h want 00000000", res); else n_pass++;
    n_total++; if (z !== 1'b1) $display("FAIL sub_zero: got %b want 1", z); else n_pass++;
    run_op(2'b10, OPC_R, 3'b101, F7_ALT, 32'h80000000, 32'd4, res, z, lat);
    $display("sra 0x80000000>>4 -> %h", res);
    n_total++; if (res !== 32'hF8000000) $display("FAIL sra_result: got %h want f8000000", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b101, 7'b0, 32'h80000000, 32'd4, res, z, lat);
    $display("srl 0x80000000>>4 -> %h", res);
    n_total++; if (res !== 32'h08000000) $display("FAIL srl_result: got %h want 08000000", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b011, 7'b0, 32'd1, 32'hFFFFFFFF, res, z, lat);
    $display("sltu 1<0xffffffff -> %h", res);
    n_total++; if (res !== 32'd1) $display("FAIL sltu_result: got %h want 00000001", res); else n_pass++;
    run_op(2'b01, OPC_B, 3'b101, 7'b0, 32'hFFFFFFFF, 32'd0, res, z, lat);
    $display("branch slt -1<0 -> %h", res);
    n_total++; if (res !== 32'd1) $display("FAIL branch_slt_result: got %h want 00000001", res); else n_pass++;
    run_op(2'b10, OPC_I, 3'b000, F7_ALT, 32'd5, 32'd3, res, z, lat);
    $display("itype f3=000 funct7[5]=1 5,3 -> %h", res);
    n_total++; if (res !== 32'd8) $display("FAIL itype_add_result: got %h want 00000008", res); else n_pass++;
  endtask

  task automatic test_mul();
    logic [31:0] res; logic z; int lat;
    int busy_cnt, rdy_low;
    alu_ctrl = 2'b10; opcode = OPC_R; funct3 = 3'b000; funct7 = F7_M;
    op_a = 32'hFFFFFFFF; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 32'h12345678; op_b = 32'h9;  // must not disturb the in-flight op
    lat = 1; busy_cnt = 0; rdy_low = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (in_ready === 1'b0) rdy_low++;
      @(negedge clk);
      lat++;
    end
    $display("mul 0xffffffff*3 -> %h lat=%0d busy=%0d in_ready_low=%0d", out_result, lat, busy_cnt, rdy_low);
    n_total++; if (lat != 33) $display("FAIL mul_latency: got %0d want 33", lat); else n_pass++;
    n_total++; if (busy_cnt != 32) $display("FAIL mul_busy_cycles: got %0d want 32", busy_cnt); else n_pass++;
    n_total++; if (rdy_low != 32) $display("FAIL mul_in_ready_low: got %0d want 32", rdy_low); else n_pass++;
    n_total++; if (out_result !== 32'hFFFFFFFD) $display("FAIL mul_result: got %h want fffffffd", out_result); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mul_busy_end: got %b want 0", busy); else n_pass++;
    run_op(2'b10, OPC_R, 3'b011, F7_M, 32'hFFFFFFFF, 32'd3, res, z, lat);
    $display("mulhu -> %h", res);
    n_total++; if (res !== 32'h2) $display("FAIL mulhu_result: got %h want 00000002", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b001, F7_M, 32'hFFFFFFFF, 32'd3, res, z, lat);
    $display("mulh -> %h", res);
    n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL mulh_result: got %h want ffffffff", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b010, F7_M, 32'hFFFFFFFF, 32'd3, res, z, lat);
    $display("mulhsu -> %h", res);
    n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL mulhsu_result: got %h want ffffffff", res); else n_pass++;
  endtask

  task automatic test_div();
    logic [31:0] res; logic z; int lat;
    run_op(2'b10, OPC_R, 3'b100, F7_M, 32'hFFFFFFF9, 32'd2, res, z, lat);
    $display("div -7/2 -> %h lat=%0d", res, lat);
    n_total++; if (res !== 32'hFFFFFFFD) $display("FAIL div_result: got %h want fffffffd", res); else n_pass++;
    n_total++; if (lat != 33) $display("FAIL div_latency: got %0d want 33", lat); else n_pass++;
    run_op(2'b10, OPC_R, 3'b110, F7_M, 32'hFFFFFFF9, 32'd2, res, z, lat);
    $display("rem -7%%2 -> %h", res);
    n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL rem_result: got %h want ffffffff", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b100, F7_M, 32'd7, 32'hFFFFFFFE, res, z, lat);
    $display("div 7/-2 -> %h", res);
    n_total++; if (res !== 32'hFFFFFFFD) $display("FAIL div_negb_result: got %h want fffffffd", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b110, F7_M, 32'd7, 32'hFFFFFFFE, res, z, lat);
    $display("rem 7%%-2 -> %h", res);
    n_total++; if (res !== 32'd1) $display("FAIL rem_negb_result: got %h want 00000001", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b101, F7_M, 32'd100, 32'd7, res, z, lat);
    $display("divu 100/7 -> %h", res);
    n_total++; if (res !== 32'd14) $display("FAIL divu_result: got %h want 0000000e", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b111, F7_M, 32'd100, 32'd7, res, z, lat);
    $display("remu 100%%7 -> %h", res);
    n_total++; if (res !== 32'd2) $display("FAIL remu_result: got %h want 00000002", res); else n_pass++;
    run_op(2'b10, OPC_R, 3'b101, F7_M, 32'd7, 32'd0, res, z, lat);
    $display("divu 7/0 -> %h lat=%0d", res, lat);
    n_total++; if (res !== 32'hFFFFFFFF) $display("FAIL divu0_result: got %h want ffffffff", res); else n_pass++;
    n_total++; if (lat != 1) $display("FAIL divu0_latency: got %0d want 1", lat); else n_pass++;
    run_op(2'b10, OPC_R, 3'b111, F7_M, 32'd7, 32'd0, res, z, lat);
    $display("remu 7%%0 -> %h lat=%0d", res, lat);
    n_total++; if (res !== 32'd7) $display("FAIL remu0_result: got %h want 00000007", res); else n_pass++;
    n_total++; if (lat != 1) $display("FAIL remu0_latency: got %0d want 1", lat); else n_pass++;
    run_op(2'b10, OPC_R, 3'b100, F7_M, 32'h80000000, 32'hFFFFFFFF, res, z, lat);
    $display("div ovf -> %h lat=%0d", res, lat);
    n_total++; if (res !== 32'h80000000) $display("FAIL divovf_result: got %h want 80000000", res); else n_pass++;
    n_total++; if (lat != 1) $display("FAIL divovf_latency: got %0d want 1", lat); else n_pass++;
    run_op(2'b10, OPC_R, 3'b110, F7_M, 32'h80000000, 32'hFFFFFFFF, res, z, lat);
    $display("rem ovf -> %h zero=%b", res, z);
    n_total++; if (res !== 32'h0) $display("FAIL removf_result: got %h want 00000000", res); else n_pass++;
    n_total++; if (z !== 1'b1) $display("FAIL removf_zero: got %b want 1", z); else n_pass++;
  endtask

  task automatic test_backpressure();
    // Drain the previous result first.
    @(negedge clk);
    out_ready = 1'b0;
    alu_ctrl = 2'b00; opcode = OPC_R; funct3 = 3'b000; funct7 = 7'b0;
    op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_a = 32'd10; op_b = 32'd20;  // second op waits while the slot is full
    n_total++; if (out_result !== 32'd3) $display("FAIL bp_first_result: got %h want 00000003", out_result); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("bp hold[%0d] result=%h valid=%b in_ready=%b", k, out_result, out_valid, in_ready);
      n_total++; if (out_result !== 32'd3) $display("FAIL bp_hold_result[%0d]: got %h want 00000003", k, out_result); else n_pass++;
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_in_ready[%0d]: got %b want 0", k, in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, out_valid); else n_pass++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    $display("bp release result=%h valid=%b", out_result, out_valid);
    n_total++; if (out_valid !== 1'b1) $display("FAIL bp_release_valid: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_result !== 32'd30) $display("FAIL bp_release_result: got %h want 0000001e", out_result); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res; logic z; int lat; int stale;
    alu_ctrl = 2'b10; opcode = OPC_R; funct3 = 3'b100; funct7 = F7_M;
    op_a = 32'd1000; op_b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    n_total++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", busy); else n_pass++;
    #1 rstn = 1'b0;
    #1;
    $display("reset at div iteration 10: valid=%b result=%h zero=%b busy=%b in_ready=%b",
             out_valid, out_result, out_zero, busy, in_ready);
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_result !== 32'h0) $display("FAIL rst_mid_result: got %h want 00000000", out_result); else n_pass++;
    n_total++; if (out_zero !== 1'b1) $display("FAIL rst_mid_zero: got %b want 1", out_zero); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    stale = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) stale++;
    end
    n_total++; if (stale != 0) $display("FAIL rst_mid_stale: got %0d valid cycles want 0", stale); else n_pass++;
    run_op(2'b00, OPC_R, 3'b000, 7'b0, 32'd3, 32'd4, res, z, lat);
    $display("post-reset add 3+4 -> %h lat=%0d", res, lat);
    n_total++; if (res !== 32'd7) $display("FAIL rst_post_add_result: got %h want 00000007", res); else n_pass++;
    n_total++; if (lat != 1) $display("FAIL rst_post_add_latency: got %0d want 1", lat); else n_pass++;
  endtask

  task automatic test_mext0();
    logic [31:0] res; logic z; int lat;
    alu_ctrl = 2'b10; opcode = OPC_R; funct3 = 3'b000; funct7 = F7_M;
    op_a = 32'd6; op_b = 32'd7; in_valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_b = 1'b0;
    $display("M_EXT=0 funct7=0000001 6,7 -> %h valid=%b", out_result_b, out_valid_b);
    n_total++; if (out_valid_b !== 1'b1) $display("FAIL mext0_valid: got %b want 1", out_valid_b); else n_pass++;
    n_total++; if (out_result_b !== 32'd13) $display("FAIL mext0_result: got %h want 0000000d", out_result_b); else n_pass++;
    n_total++; if (busy_b !== 1'b0) $display("FAIL mext0_busy: got %b want 0", busy_b); else n_pass++;
    run_op(2'b10, OPC_R, 3'b000, F7_M, 32'd6, 32'd7, res, z, lat);
    $display("M_EXT=1 same encoding 6,7 -> %h lat=%0d", res, lat);
    n_total++; if (res !== 32'd42) $display("FAIL mext1_mul_result: got %h want 0000002a", res); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_rtype();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_div();
    test_mext0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
